// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU output stage: op codes, flag bit
// positions and result-buffer state encodings.
package alu4_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu4_flag_gen.sv
// Combinational N/Z/C/V flag generation for one ALU result.
// C and V are forced to 0 for ops not marked arithmetic in ARITH_OPS.
module alu4_flag_gen
  import alu4_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter logic [7:0]  ARITH_OPS = 8'b1111_0000
) (
  input  logic [WIDTH-1:0] result,
  input  logic [2:0]       op,
  input  logic             co,
  input  logic             c3,
  output logic [3:0]       flags
);

  logic arith;

  always_comb begin
    arith         = ARITH_OPS[op];
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = arith & co;
    flags[FLAG_V] = arith & (co ^ c3);
  end

endmodule

// File: rtl/alu4_result_buf.sv
// ALU result output stage: flags computed at push time, 2-entry skid FIFO
// with valid/ready. Optional push/stall counters via ALU4_RESULT_BUF_STATS_EN.
module alu4_result_buf
  import alu4_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter logic [7:0]  ARITH_OPS = 8'b1111_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_op,
  input  logic             in_co,
  input  logic             in_c3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
`ifdef ALU4_RESULT_BUF_STATS_EN
  output logic [7:0]       push_cnt,
  output logic [7:0]       stall_cnt,
`endif
  output logic [3:0]       out_flags
);

  buf_state_t       state, state_next;
  logic             wr_ptr, rd_ptr;
  logic [WIDTH-1:0] slot_result [2];
  logic [2:0]       slot_op     [2];
  logic [3:0]       slot_flags  [2];
  logic [3:0]       push_flags;
  logic             push, pop;

  // Handshake outputs come only from registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  alu4_flag_gen #(
    .WIDTH     (WIDTH),
    .ARITH_OPS (ARITH_OPS)
  ) u_flag_gen (
    .result (in_result),
    .op     (in_op),
    .co     (in_co),
    .c3     (in_c3),
    .flags  (push_flags)
  );

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:  if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        slot_result[i] <= '0;
        slot_op[i]     <= '0;
        slot_flags[i]  <= '0;
      end
    end else begin
      state <= state_next;
      if (push) begin
        slot_result[wr_ptr] <= in_result;
        slot_op[wr_ptr]     <= in_op;
        slot_flags[wr_ptr]  <= push_flags;
        wr_ptr              <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign out_result = slot_result[rd_ptr];
  assign out_op     = slot_op[rd_ptr];
  assign out_flags  = slot_flags[rd_ptr];

`ifdef ALU4_RESULT_BUF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (push)                   push_cnt  <= push_cnt + 8'd1;
      if (out_valid & ~out_ready) stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu4_result_buf.sv
// Self-checking bench for alu4_result_buf: flag vector table, directed
// handshake/reset sequences and a randomized run against a queue model.
module tb_alu4_result_buf;

  localparam int unsigned WIDTH = 4;
  localparam logic [7:0]  ARITH = 8'b1111_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_op;
  logic             in_co;
  logic             in_c3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_op;
  logic [3:0]       out_flags;
`ifdef ALU4_RESULT_BUF_STATS_EN
  logic [7:0]       push_cnt;
  logic [7:0]       stall_cnt;
  int               m_push;
  int               m_stall;
`endif

  always #5 clk = ~clk;

  alu4_result_buf #(
    .WIDTH     (WIDTH),
    .ARITH_OPS (ARITH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .in_co      (in_co),
    .in_c3      (in_c3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
`ifdef ALU4_RESULT_BUF_STATS_EN
    .push_cnt   (push_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .out_flags  (out_flags)
  );

  typedef struct {
    logic [3:0] result;
    logic [2:0] op;
    logic [3:0] flags;
  } ent_t;

  typedef struct {
    logic [3:0] r;
    logic [2:0] op;
    logic       co;
    logic       c3;
    logic [3:0] exp;
  } vec_t;

  ent_t q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [3:0] ref_flags(input int r, input int op,
                                           input logic co, input logic c3);
    logic arith;
    arith = ARITH[op];
    return {r >= 8, r == 0, arith && co, arith && (co != c3)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".result"}, 32'(out_result), 32'(q[0].result));
      chk({tag, ".op"},     32'(out_op),     32'(q[0].op));
      chk({tag, ".flags"},  32'(out_flags),  32'(q[0].flags));
    end else begin
      chk({tag, ".no_x"}, 32'($isunknown({out_result, out_op, out_flags})), 32'd0);
    end
`ifdef ALU4_RESULT_BUF_STATS_EN
    chk({tag, ".push_cnt"},  32'(push_cnt),  32'(m_push % 256));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall % 256));
`endif
  endtask

  // Called at a negedge: drive, predict across the next posedge, check at next negedge.
  task automatic cycle(input logic v, input logic [3:0] r, input logic [2:0] op,
                       input logic co, input logic c3, input logic rdy, input string tag);
    bit do_push, do_pop;
    in_valid  = v;
    in_result = r;
    in_op     = op;
    in_co     = co;
    in_c3     = c3;
    out_ready = rdy;
    do_push = v && (q.size() < 2);
    do_pop  = rdy && (q.size() > 0);
`ifdef ALU4_RESULT_BUF_STATS_EN
    if (do_push) m_push++;
    if ((q.size() > 0) && !rdy) m_stall++;
`endif
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{result: r, op: op, flags: ref_flags(int'(r), int'(op), co, c3)});
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
`ifdef ALU4_RESULT_BUF_STATS_EN
    m_push  = 0;
    m_stall = 0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{r: 4'h0, op: 3'd5, co: 1'b1, c3: 1'b1, exp: 4'b0110};
    vecs[1] = '{r: 4'h8, op: 3'd4, co: 1'b0, c3: 1'b1, exp: 4'b1001};
    vecs[2] = '{r: 4'h8, op: 3'd1, co: 1'b0, c3: 1'b1, exp: 4'b1000};
    vecs[3] = '{r: 4'h7, op: 3'd0, co: 1'b1, c3: 1'b0, exp: 4'b0000};
    vecs[4] = '{r: 4'hF, op: 3'd7, co: 1'b1, c3: 1'b1, exp: 4'b1010};
    vecs[5] = '{r: 4'h1, op: 3'd6, co: 1'b0, c3: 1'b1, exp: 4'b0001};
    vecs[6] = '{r: 4'h0, op: 3'd2, co: 1'b1, c3: 1'b0, exp: 4'b0100};

    in_valid = 0; in_result = '0; in_op = '0; in_co = 0; in_c3 = 0; out_ready = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.result",    32'(out_result), 32'd0);
    chk("rst.op",        32'(out_op),     32'd0);
    chk("rst.flags",     32'(out_flags),  32'd0);
    do_reset();

    // Flag vectors: push one entry, check it, drain.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, vecs[i].r, vecs[i].op, vecs[i].co, vecs[i].c3, 1'b1, "vec");
      chk($sformatf("vec%0d.valid", i),  32'(out_valid),  32'd1);
      chk($sformatf("vec%0d.result", i), 32'(out_result), 32'(vecs[i].r));
      chk($sformatf("vec%0d.flags", i),  32'(out_flags),  32'(vecs[i].exp));
      cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, "drain");
    end

    // Stalled consumer: fill, ignored third push, drain in order.
    cycle(1'b1, 4'h7, 3'd0, 1'b0, 1'b0, 1'b0, "fill1");
    chk("fill1.in_ready", 32'(in_ready), 32'd1);
    cycle(1'b1, 4'h9, 3'd0, 1'b0, 1'b0, 1'b0, "fill2");
    chk("fill2.in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'h3, 3'd0, 1'b0, 1'b0, 1'b0, "ignored");
    chk("ignored.head", 32'(out_result), 32'h7);
    cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, "pop1");
    chk("pop1.head", 32'(out_result), 32'h9);
    cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, "pop2");
    chk("pop2.out_valid", 32'(out_valid), 32'd0);

    // Streaming: one in, one out per cycle, one-cycle lag.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'(i), 3'd4, 1'b0, 1'b0, 1'b1, "stream");
      chk($sformatf("stream%0d.head", i),  32'(out_result), 32'(i));
      chk($sformatf("stream%0d.ready", i), 32'(in_ready),   32'd1);
    end
    cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, "stream_end");

    // Asynchronous reset between edges while FULL.
    cycle(1'b1, 4'hA, 3'd5, 1'b1, 1'b0, 1'b0, "af1");
    cycle(1'b1, 4'hB, 3'd5, 1'b1, 1'b0, 1'b0, "af2");
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async.out_valid", 32'(out_valid),  32'd0);
    chk("async.in_ready",  32'(in_ready),   32'd1);
    chk("async.result",    32'(out_result), 32'd0);
    chk("async.flags",     32'(out_flags),  32'd0);
    @(negedge clk);
    do_reset();
    cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, "post_rst");
    cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, "post_rst2");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
    end

`ifdef ALU4_RESULT_BUF_STATS_EN
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'(i), 3'd0, 1'b0, 1'b0, 1'b1, "cnt");
    chk("push_cnt.300", 32'(push_cnt), 32'd44);
    begin
      logic [7:0] s0;
      s0 = stall_cnt;
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, "stall");
      chk("stall_cnt.+5", 32'(stall_cnt - s0), 32'd5);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
